// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: load/mul opcode bit positions
// and the idle trace PC.
package wb_stage_pkg;
    localparam int LD_B  = 0;
    localparam int LD_H  = 1;
    localparam int LD_W  = 2;
    localparam int LD_BU = 3;
    localparam int LD_HU = 4;

    localparam int MUL_W   = 0;
    localparam int MULH_W  = 1;
    localparam int MULH_WU = 2;

    localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
endpackage

// File: rtl/wb_load_align.sv
// Load alignment: picks the byte/halfword addressed by off and extends it.
module wb_load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] i_rd,
    input  logic [1:0]  i_off,
    input  logic [7:0]  i_load_op,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rd[8*i_off +: 8];
    assign w_half = i_off[1] ? i_rd[31:16] : i_rd[15:0];

    always_comb begin
        o_data = i_rd;
        if (i_load_op[LD_B])
            o_data = {{24{w_byte[7]}}, w_byte};
        else if (i_load_op[LD_BU])
            o_data = {24'b0, w_byte};
        else if (i_load_op[LD_H])
            o_data = {{16{w_half[15]}}, w_half};
        else if (i_load_op[LD_HU])
            o_data = {16'b0, w_half};
    end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle, capturing first-cycle
// SRAM/multiplier data so a trace back-pressure stall never loses it.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] result,
    input  logic [31:0] PC,
    input  logic [7:0]  load_op,
    input  logic [2:0]  mul_op,
    input  logic        res_from_mul,
    input  logic        res_from_div,
    input  logic        res_from_mem,
    input  logic        gr_we,
    input  logic [4:0]  dest,
    input  logic [31:0] data_sram_rdata,
    input  logic [63:0] mul_result,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_dest,
    output logic [31:0] fwd_data,
    output logic        debug_wb_valid,
    input  logic        debug_wb_ready,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [63:0] instret
);
    logic        r_held;
    logic [31:0] r_hold_rdata;
    logic [63:0] r_hold_mul;
    logic [63:0] r_instret;

    logic        w_retire;
    logic        w_wen;
    logic [31:0] w_rd;
    logic [63:0] w_mr;
    logic [31:0] w_ld_data;
    logic [31:0] w_mul_data;
    logic [31:0] w_wdata;

    assign w_retire = in_valid & debug_wb_ready;
    assign in_ready = ~in_valid | w_retire;

    // Capture only on an instruction's first cycle; later cycles see stale SRAM/mul data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_held       <= 1'b0;
            r_hold_rdata <= 32'b0;
            r_hold_mul   <= 64'b0;
            r_instret    <= 64'b0;
        end else begin
            if (w_retire)
                r_held <= 1'b0;
            else if (in_valid)
                r_held <= 1'b1;
            if (in_valid && !r_held && !w_retire) begin
                r_hold_rdata <= data_sram_rdata;
                r_hold_mul   <= mul_result;
            end
            if (w_retire)
                r_instret <= r_instret + 64'd1;
        end
    end

    assign w_rd = r_held ? r_hold_rdata : data_sram_rdata;
    assign w_mr = r_held ? r_hold_mul   : mul_result;

    wb_load_align u_align (
        .i_rd      (w_rd),
        .i_off     (result[1:0]),
        .i_load_op (load_op),
        .o_data    (w_ld_data)
    );

    assign w_mul_data = (mul_op[MULH_W] | mul_op[MULH_WU]) ? w_mr[63:32] : w_mr[31:0];

    // Divider results arrive through result, so res_from_div needs no path of its own.
    always_comb begin
        w_wdata = result;
        if (res_from_mem)
            w_wdata = w_ld_data;
        else if (res_from_mul)
            w_wdata = w_mul_data;
    end

    assign w_wen = in_valid & gr_we & (dest != 5'd0);

    assign rf_we    = w_wen & w_retire;
    assign rf_waddr = dest;
    assign rf_wdata = w_wdata;

    assign fwd_valid = w_wen;
    assign fwd_dest  = dest;
    assign fwd_data  = w_wdata;

    assign debug_wb_valid    = in_valid;
    assign debug_wb_pc       = in_valid ? PC : RESET_PC;
    assign debug_wb_rf_we    = {4{w_wen}};
    assign debug_wb_rf_wnum  = dest;
    assign debug_wb_rf_wdata = w_wdata;

    assign instret = r_instret;

    logic w_unused;
    assign w_unused = res_from_div;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load alignment, mul select, stall hold, reset mid-stall.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic [31:0] PC;
    logic [7:0]  load_op;
    logic [2:0]  mul_op;
    logic        res_from_mul, res_from_div, res_from_mem, gr_we;
    logic [4:0]  dest;
    logic [31:0] data_sram_rdata;
    logic [63:0] mul_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic        debug_wb_valid;
    logic        debug_wb_ready;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [63:0] instret;

    int n_chk  = 0;
    int n_fail = 0;
    int n_we   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_we) n_we <= n_we + 1;

    wb_stage #(.RESET_PC(32'h1c000000)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .PC(PC), .load_op(load_op), .mul_op(mul_op),
        .res_from_mul(res_from_mul), .res_from_div(res_from_div),
        .res_from_mem(res_from_mem), .gr_we(gr_we), .dest(dest),
        .data_sram_rdata(data_sram_rdata), .mul_result(mul_result),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .debug_wb_valid(debug_wb_valid), .debug_wb_ready(debug_wb_ready),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .instret(instret)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an instruction at the falling edge; outputs are checked 1 ns later.
    task automatic issue(input logic [7:0] lop, input logic [2:0] mop, input logic mem,
                         input logic mul, input logic [4:0] dst, input logic [31:0] res,
                         input logic [31:0] rd, input logic [63:0] mr, input logic rdy);
        @(negedge clk);
        in_valid = 1'b1; load_op = lop; mul_op = mop; res_from_mem = mem;
        res_from_mul = mul; res_from_div = 1'b0; gr_we = 1'b1; dest = dst;
        result = res; PC = 32'h1c000100 + res; data_sram_rdata = rd;
        mul_result = mr; debug_wb_ready = rdy;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; debug_wb_ready = 1'b1;
        #1;
    endtask

    initial begin
        int we0;
        resetn = 1'b0; in_valid = 1'b0; result = '0; PC = '0; load_op = '0;
        mul_op = '0; res_from_mul = 0; res_from_div = 0; res_from_mem = 0;
        gr_we = 0; dest = '0; data_sram_rdata = '0; mul_result = '0;
        debug_wb_ready = 1'b1;
        #12;
        chk("rst_instret", instret, 64'd0);
        chk("rst_rf_we", {63'b0, rf_we}, 64'd0);
        chk("rst_fwd_valid", {63'b0, fwd_valid}, 64'd0);
        chk("rst_dbg_valid", {63'b0, debug_wb_valid}, 64'd0);
        chk("rst_dbg_pc", {32'b0, debug_wb_pc}, 64'h1c000000);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk); resetn = 1'b1;

        // LD.B off=3
        issue(8'h01, 3'b000, 1, 0, 5'd5, 32'h3, 32'h80123456, 64'd0, 1);
        chk("ldb_wdata", {32'b0, rf_wdata}, 64'hFFFFFF80);
        chk("ldb_we", {63'b0, rf_we}, 64'd1);
        chk("ldb_waddr", {59'b0, rf_waddr}, 64'd5);
        chk("ldb_instret0", instret, 64'd0);
        idle();
        chk("ldb_instret1", instret, 64'd1);
        chk("idle_we", {63'b0, rf_we}, 64'd0);

        issue(8'h10, 3'b000, 1, 0, 5'd6, 32'h2, 32'hBEEF1234, 64'd0, 1);
        chk("ldhu_wdata", {32'b0, rf_wdata}, 64'h0000BEEF);
        issue(8'h02, 3'b000, 1, 0, 5'd6, 32'h2, 32'hBEEF1234, 64'd0, 1);
        chk("ldh_wdata", {32'b0, rf_wdata}, 64'hFFFFBEEF);
        issue(8'h08, 3'b000, 1, 0, 5'd6, 32'h1, 32'h0000A500, 64'd0, 1);
        chk("ldbu_wdata", {32'b0, rf_wdata}, 64'h000000A5);

        // LD.W with a 3-cycle stall; SRAM data goes stale after the first cycle
        idle();
        we0 = n_we;
        issue(8'h04, 3'b000, 1, 0, 5'd7, 32'h0, 32'h11223344, 64'd0, 0);
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        chk("stall_fwd0", {32'b0, fwd_data}, 64'h11223344);
        chk("stall_fwd_valid", {63'b0, fwd_valid}, 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); data_sram_rdata = 32'hDEADBEEF; #1;
            chk("stall_fwd", {32'b0, fwd_data}, 64'h11223344);
            chk("stall_we", {63'b0, rf_we}, 64'd0);
            chk("stall_in_ready2", {63'b0, in_ready}, 64'd0);
        end
        @(negedge clk); debug_wb_ready = 1'b1; #1;
        chk("stall_ret_wdata", {32'b0, rf_wdata}, 64'h11223344);
        chk("stall_ret_we", {63'b0, rf_we}, 64'd1);
        idle();
        chk("stall_we_once", 64'(n_we - we0), 64'd1);
        chk("stall_instret", instret, 64'd5);

        // Multiplier high/low select
        issue(8'h00, 3'b010, 0, 1, 5'd8, 32'h0, 32'h0, 64'hFFFFFFFF_00000002, 1);
        chk("mulh_wdata", {32'b0, rf_wdata}, 64'hFFFFFFFF);
        issue(8'h00, 3'b001, 0, 1, 5'd8, 32'h0, 32'h0, 64'hFFFFFFFF_00000002, 1);
        chk("mul_wdata", {32'b0, rf_wdata}, 64'h00000002);

        // dest = 0 never writes but still retires and traces
        issue(8'h00, 3'b000, 0, 0, 5'd0, 32'h40, 32'h0, 64'd0, 1);
        chk("d0_we", {63'b0, rf_we}, 64'd0);
        chk("d0_fwd_valid", {63'b0, fwd_valid}, 64'd0);
        chk("d0_dbg_valid", {63'b0, debug_wb_valid}, 64'd1);
        chk("d0_dbg_pc", {32'b0, debug_wb_pc}, 64'h1c000140);
        chk("d0_dbg_we", {60'b0, debug_wb_rf_we}, 64'd0);
        chk("d0_wdata", {32'b0, rf_wdata}, 64'h40);
        idle();
        chk("d0_instret", instret, 64'd8);

        // Stall, retire, then a new load arrives at the same edge: must use live data
        issue(8'h04, 3'b000, 1, 0, 5'd9, 32'h0, 32'hCAFE0001, 64'd0, 0);
        @(negedge clk); data_sram_rdata = 32'h0BAD0BAD; debug_wb_ready = 1'b1; #1;
        chk("b2b_ret_wdata", {32'b0, rf_wdata}, 64'hCAFE0001);
        issue(8'h04, 3'b000, 1, 0, 5'd9, 32'h0, 32'h5EED5EED, 64'd0, 1);
        chk("b2b_live_wdata", {32'b0, rf_wdata}, 64'h5EED5EED);
        idle();
        chk("b2b_instret", instret, 64'd10);

        // Reset mid-stall drops the instruction and the held data
        issue(8'h04, 3'b000, 1, 0, 5'd10, 32'h0, 32'hAAAA5555, 64'd0, 0);
        @(negedge clk); data_sram_rdata = 32'h0; #1;
        chk("pre_rst_fwd", {32'b0, fwd_data}, 64'hAAAA5555);
        resetn = 1'b0; in_valid = 1'b0; #1;
        chk("mid_rst_instret", instret, 64'd0);
        chk("mid_rst_pc", {32'b0, debug_wb_pc}, 64'h1c000000);
        @(negedge clk); resetn = 1'b1;
        issue(8'h04, 3'b000, 1, 0, 5'd11, 32'h0, 32'h12345678, 64'd0, 1);
        chk("post_rst_live", {32'b0, rf_wdata}, 64'h12345678);
        chk("post_rst_we", {63'b0, rf_we}, 64'd1);
        idle();
        chk("post_rst_instret", instret, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
